// File: rtl/and_or_pipe.sv
// Parameterised AND-OR / OR-AND / AND-XOR / bypass reduction over TERMS operand
// lanes, followed by a STAGES-deep enable-gated pipeline and a saturating hit counter.
module and_or_pipe #(
    parameter int WIDTH  = 8,
    parameter int TERMS  = 2,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   in_valid,
    input  logic [1:0]             mode,
    input  logic [TERMS*WIDTH-1:0] a,
    input  logic [TERMS*WIDTH-1:0] b,
    input  logic                   clr_cnt,
    output logic [WIDTH-1:0]       f,
    output logic                   out_valid,
    output logic [15:0]            hit_cnt
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    logic [WIDTH-1:0]              w_result;
    logic [STAGES-1:0][WIDTH-1:0]  w_stage_d;
    logic [STAGES-1:0]             w_stage_v;
    logic                          w_hit;
    logic [STAGES-1:0][WIDTH-1:0]  r_data;
    logic [STAGES-1:0]             r_vld;
    logic [15:0]                   r_hit_cnt;

    // Lane reduction selected by mode; TERMS=1 degenerates to a single a_0/b_0 term.
    always_comb begin
        w_result = {WIDTH{1'b0}};
        case (mode)
            2'b00: begin
                for (int i = 0; i < TERMS; i++)
                    w_result = w_result | (a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH]);
            end
            2'b01: begin
                w_result = {WIDTH{1'b1}};
                for (int i = 0; i < TERMS; i++)
                    w_result = w_result & (a[i*WIDTH +: WIDTH] | b[i*WIDTH +: WIDTH]);
            end
            2'b10: begin
                for (int i = 0; i < TERMS; i++)
                    w_result = w_result ^ (a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH]);
            end
            2'b11: begin
                w_result = a[WIDTH-1:0];
            end
            default: begin
                w_result = {WIDTH{1'b0}};
            end
        endcase
    end

    // Next-value of every stage: stage 0 takes the fresh result, later stages shift.
    always_comb begin
        w_stage_d[0] = w_result;
        w_stage_v[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            w_stage_d[s] = r_data[s-1];
            w_stage_v[s] = r_vld[s-1];
        end
    end

    // A hit is judged on what the final stage is about to load, not what it holds.
    assign w_hit = w_stage_v[STAGES-1] && (w_stage_d[STAGES-1] != {WIDTH{1'b0}});

    // Pipeline registers; en=0 freezes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= {(STAGES*WIDTH){1'b0}};
            r_vld  <= {STAGES{1'b0}};
        end else if (en) begin
            r_data <= w_stage_d;
            r_vld  <= w_stage_v;
        end
    end

    // Saturating hit counter; clear takes priority and is itself gated by en.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt <= 16'd0;
        end else if (en) begin
            if (clr_cnt)
                r_hit_cnt <= 16'd0;
            else if (w_hit && (r_hit_cnt != CNT_MAX))
                r_hit_cnt <= r_hit_cnt + 16'd1;
        end
    end

    assign f         = r_data[STAGES-1];
    assign out_valid = r_vld[STAGES-1];
    assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_and_or_pipe.sv
// Randomised and directed bench for and_or_pipe (WIDTH=8, TERMS=2, STAGES=2),
// checked against a queue-based delay model built from the functional rules.
module tb_and_or_pipe;

    localparam int W = 8;
    localparam int T = 2;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           en;
    logic           in_valid;
    logic [1:0]     mode;
    logic [T*W-1:0] a;
    logic [T*W-1:0] b;
    logic           clr_cnt;
    logic [W-1:0]   f;
    logic           out_valid;
    logic [15:0]    hit_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_cnt;

    and_or_pipe #(.WIDTH(W), .TERMS(T), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode),
        .a(a), .b(b), .clr_cnt(clr_cnt),
        .f(f), .out_valid(out_valid), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_f(input logic [1:0] m, input logic [15:0] av,
                                           input logic [15:0] bv);
        logic [7:0] a0, a1, b0, b1;
        a0 = av[7:0];  a1 = av[15:8];
        b0 = bv[7:0];  b1 = bv[15:8];
        case (m)
            2'b00:   return (a0 & b0) | (a1 & b1);
            2'b01:   return (a0 | b0) & (a1 | b1);
            2'b10:   return (a0 & b0) ^ (a1 & b1);
            default: return a0;
        endcase
    endfunction

    task automatic model_reset();
        ent_t z;
        z = '{v: 1'b0, d: 8'h00};
        mq.delete();
        for (int i = 0; i < S; i++) mq.push_back(z);
        m_cnt = 0;
    endtask

    // One rising edge; the model's output is the entry accepted S-1 enabled edges ago.
    task automatic cycle();
        ent_t e;
        logic en_s, clr_s;
        e.v   = in_valid;
        e.d   = ref_f(mode, a, b);
        en_s  = en;
        clr_s = clr_cnt;
        @(posedge clk);
        if (en_s) begin
            mq.push_back(e);
            void'(mq.pop_front());
            if (clr_s) m_cnt = 0;
            else if (mq[0].v && mq[0].d != 8'h00 && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b1; in_valid = 1'b0; mode = 2'b00; a = 16'h0000; b = 16'h0000; clr_cnt = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #2;
        n_cmp++; if (f !== 8'h00) begin n_bad++; $display("FAIL reset_f: got %h want 00", f); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_cmp++; if (hit_cnt !== 16'h0000) begin n_bad++; $display("FAIL reset_cnt: got %h want 0000", hit_cnt); end
        #10;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_and_or();
        mode = 2'b00; a = {8'h01, 8'hF0}; b = {8'h01, 8'h3C}; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        cycle();
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL andor_valid: got %b want 1", out_valid); end
        n_cmp++; if (f !== 8'h31) begin n_bad++; $display("FAIL andor_f: got %h want 31", f); end
        n_cmp++; if (hit_cnt !== 16'd1) begin n_bad++; $display("FAIL andor_cnt: got %0d want 1", hit_cnt); end
    endtask

    task automatic test_mode_seq();
        logic [15:0] c0;
        c0 = 16'(m_cnt);
        mode = 2'b01; a = {8'h00, 8'h0F}; b = {8'h81, 8'hF0}; in_valid = 1'b1;
        cycle();
        mode = 2'b10; a = {8'hFF, 8'hFF}; b = {8'h0F, 8'h0F};
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || f !== 8'h81) begin n_bad++; $display("FAIL orand_f: got %b/%h want 1/81", out_valid, f); end
        n_cmp++; if (hit_cnt !== c0 + 16'd1) begin n_bad++; $display("FAIL orand_cnt: got %0d want %0d", hit_cnt, c0 + 16'd1); end
        cycle();
        n_cmp++; if (out_valid !== 1'b1 || f !== 8'h00) begin n_bad++; $display("FAIL andxor_f: got %b/%h want 1/00", out_valid, f); end
        n_cmp++; if (hit_cnt !== c0 + 16'd1) begin n_bad++; $display("FAIL andxor_cnt: got %0d want %0d", hit_cnt, c0 + 16'd1); end
    endtask

    task automatic test_stall();
        logic [15:0] c0;
        c0 = 16'(m_cnt);
        mode = 2'b00; a = {8'h00, 8'hFF}; b = {8'h00, 8'h5A}; in_valid = 1'b1;
        cycle();
        in_valid = 1'b0; en = 1'b0; clr_cnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid%0d: got %b want 0", i, out_valid); end
            n_cmp++; if (hit_cnt !== c0) begin n_bad++; $display("FAIL stall_cnt%0d: got %0d want %0d", i, hit_cnt, c0); end
        end
        en = 1'b1; clr_cnt = 1'b0;
        cycle();
        n_cmp++; if (out_valid !== 1'b1 || f !== 8'h5A) begin n_bad++; $display("FAIL stall_out: got %b/%h want 1/5a", out_valid, f); end
        n_cmp++; if (hit_cnt !== c0 + 16'd1) begin n_bad++; $display("FAIL stall_inc: got %0d want %0d", hit_cnt, c0 + 16'd1); end
    endtask

    task automatic test_bypass_toggle();
        logic [3:0] vin;
        logic [3:0] vexp;
        vin  = 4'b0101;
        vexp = 4'b1010;
        mode = 2'b11; a = {8'h77, 8'hA5}; b = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            in_valid = vin[i];
            cycle();
            n_cmp++; if (out_valid !== vexp[i]) begin n_bad++; $display("FAIL bypass_valid%0d: got %b want %b", i, out_valid, vexp[i]); end
            if (vexp[i]) begin
                n_cmp++; if (f !== 8'hA5) begin n_bad++; $display("FAIL bypass_f%0d: got %h want a5", i, f); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        en = 1'b1; clr_cnt = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; mode = 2'($urandom_range(3, 0));
            a = 16'($urandom); b = 16'($urandom);
            cycle();
            n_cmp++; if (out_valid !== mq[0].v) begin n_bad++; $display("FAIL b2b_valid%0d: got %b want %b", i, out_valid, mq[0].v); end
            if (i > 0) begin
                n_cmp++; if (f !== mq[0].d) begin n_bad++; $display("FAIL b2b_f%0d: got %h want %h", i, f, mq[0].d); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(9, 0) < 8);
            in_valid = 1'($urandom);
            clr_cnt  = ($urandom_range(19, 0) == 0);
            mode     = 2'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            cycle();
            n_cmp++; if (out_valid !== mq[0].v) begin n_bad++; $display("FAIL rnd_valid%0d: got %b want %b", i, out_valid, mq[0].v); end
            if (mq[0].v) begin
                n_cmp++; if (f !== mq[0].d) begin n_bad++; $display("FAIL rnd_f%0d: got %h want %h", i, f, mq[0].d); end
            end
            n_cmp++; if (hit_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt%0d: got %0d want %0d", i, hit_cnt, m_cnt); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_flight();
        idle_inputs();
        mode = 2'b11; a = {8'h00, 8'hC3}; in_valid = 1'b1;
        cycle();
        cycle();
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (f !== 8'h00) begin n_bad++; $display("FAIL rstfly_f: got %h want 00", f); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfly_valid: got %b want 0", out_valid); end
        n_cmp++; if (hit_cnt !== 16'h0000) begin n_bad++; $display("FAIL rstfly_cnt: got %h want 0000", hit_cnt); end
        a = {8'h00, 8'h3C}; in_valid = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        cycle();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstfly_stale: got %b want 0", out_valid); end
        cycle();
        n_cmp++; if (out_valid !== 1'b1 || f !== 8'h3C) begin n_bad++; $display("FAIL rstfly_first: got %b/%h want 1/3c", out_valid, f); end
    endtask

    task automatic test_saturation();
        idle_inputs();
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0; mode = 2'b11; a = {8'h00, 8'h01}; in_valid = 1'b1;
        for (int i = 0; i < 65537 + S; i++) cycle();
        n_cmp++; if (hit_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_cnt: got %h want ffff", hit_cnt); end
        n_cmp++; if (hit_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL sat_model: got %h want %h", hit_cnt, m_cnt); end
        clr_cnt = 1'b1;
        cycle();
        n_cmp++; if (hit_cnt !== 16'h0000) begin n_bad++; $display("FAIL sat_clr: got %h want 0000", hit_cnt); end
        clr_cnt = 1'b0;
        cycle();
        n_cmp++; if (hit_cnt !== 16'h0001) begin n_bad++; $display("FAIL sat_after_clr: got %h want 0001", hit_cnt); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_and_or();
        test_mode_seq();
        test_stall();
        test_bypass_toggle();
        test_back_to_back();
        test_random();
        test_reset_in_flight();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
